// File: rtl/grid_cmd_if.sv
// Command/response bundle for grid_cmd_engine.
// Master issues cell/row commands; slave returns row readback.
interface grid_cmd_if #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  localparam int YW = $clog2(GRID_H)
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [XW-1:0]     cmd_x;
  logic [YW-1:0]     cmd_y;
  logic [GRID_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [GRID_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/grid_cmd_engine.sv
// Bit-grid command executor with live population count
// and a registered display row read port.
module grid_cmd_engine #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  localparam int YW = $clog2(GRID_H),
  localparam int CW = $clog2(GRID_W*GRID_H+1)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  grid_cmd_if.slave         cmd,
  output logic              busy,
  output logic              err,
  output logic [CW-1:0]     cell_count,
  input  logic [YW-1:0]     disp_row_addr,
  output logic [GRID_W-1:0] disp_row_data
);

  localparam int unsigned WN = GRID_W;
  localparam int unsigned HN = GRID_H;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_SET  = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_TOG  = 3'd3;
  localparam logic [2:0] OP_RD   = 3'd4;
  localparam logic [2:0] OP_WR   = 3'd5;
  localparam logic [2:0] OP_CALL = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SWEEP
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [GRID_W-1:0] data_q, data_d;
  logic [YW-1:0]     ptr_q, ptr_d;

  logic [GRID_W-1:0] grid_q [GRID_H];

  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [GRID_W-1:0] rsp_data_q, rsp_data_d;
  logic [GRID_W-1:0] disp_q, disp_d;

  logic              hs;
  logic              x_ok;
  logic [YW-1:0]     row_sel;
  logic              row_ok;
  logic [GRID_W-1:0] old_row;
  logic              wr_en;
  logic [GRID_W-1:0] wr_val;

  // Ready is forced low while reset is held.
  assign cmd.cmd_ready = (state_q == IDLE) && ARESETN;
  assign hs            = cmd.cmd_valid && cmd.cmd_ready;

  // Next-state: accept in IDLE, one EXEC cycle, or a row sweep.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          op_d   = cmd.cmd_op;
          x_d    = cmd.cmd_x;
          y_d    = cmd.cmd_y;
          data_d = cmd.cmd_data;
          ptr_d  = '0;
          if (cmd.cmd_op == OP_CALL) begin
            state_d = SWEEP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
      end
      SWEEP: begin
        ptr_d = ptr_q + YW'(1);
        if (32'(ptr_q) == HN - 1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Row selection and the single grid write port.
  always_comb begin
    row_sel     = (state_q == SWEEP) ? ptr_q : y_q;
    row_ok      = 32'(row_sel) < HN;
    x_ok        = 32'(x_q) < WN;
    old_row     = row_ok ? grid_q[row_sel] : '0;
    wr_en       = 1'b0;
    wr_val      = old_row;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    if (state_q == SWEEP) begin
      wr_en  = 1'b1;
      wr_val = '0;
    end else if (state_q == EXEC) begin
      unique case (op_q)
        OP_SET, OP_CLR, OP_TOG: begin
          if (row_ok && x_ok) begin
            wr_en = 1'b1;
            if (op_q == OP_SET) begin
              wr_val[x_q] = 1'b1;
            end else if (op_q == OP_CLR) begin
              wr_val[x_q] = 1'b0;
            end else begin
              wr_val[x_q] = ~old_row[x_q];
            end
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RD: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = old_row;
          if (!row_ok) begin
            err_d = 1'b1;
          end
        end
        OP_WR: begin
          if (row_ok) begin
            wr_en  = 1'b1;
            wr_val = data_q;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RSVD: begin
          err_d = 1'b1;
        end
        OP_NOP, OP_CALL: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Population count follows every row rewrite.
  always_comb begin
    count_d = count_q;
    if (wr_en) begin
      count_d = count_q - CW'($countones(old_row))
                        + CW'($countones(wr_val));
    end
  end

  // Display port sees the grid as of the previous edge.
  always_comb begin
    disp_d = '0;
    if (32'(disp_row_addr) < HN) begin
      disp_d = grid_q[disp_row_addr];
    end
  end

  // Control state and latched command.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  // Grid storage, fully zeroed by reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int r = 0; r < GRID_H; r++) begin
        grid_q[r] <= '0;
      end
    end else if (wr_en) begin
      grid_q[row_sel] <= wr_val;
    end
  end

  // Response, error, count and display registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      count_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      disp_q      <= '0;
    end else begin
      count_q     <= count_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      disp_q      <= disp_d;
    end
  end

  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_data  = rsp_data_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;
  assign cell_count    = count_q;
  assign disp_row_data = disp_q;

endmodule
